// File: rtl/edge_evt_pkg.sv
// Shared types for the edge event arbiter: per-channel edge mode encoding
// and the edge qualification helper used by each channel slice.
package edge_evt_pkg;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_RISE = 2'b01,
      MODE_FALL = 2'b10,
      MODE_BOTH = 2'b11
   } edge_mode_t;

   localparam int MAX_CH = 16;

   function automatic logic edge_qualify(edge_mode_t mode, logic rise, logic fall);
      return (rise && (mode == MODE_RISE || mode == MODE_BOTH)) ||
             (fall && (mode == MODE_FALL || mode == MODE_BOTH));
   endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event channel carrying the granted channel index and edge type.
interface edge_event_arbiter_if #(
   parameter int CH_W = 2
);
   logic            evt_valid_o;
   logic            evt_ready_i;
   logic [CH_W-1:0] evt_ch_o;
   logic            evt_rise_o;

   modport master (output evt_valid_o, output evt_ch_o, output evt_rise_o, input evt_ready_i);
   modport slave  (input evt_valid_o, input evt_ch_o, input evt_rise_o, output evt_ready_i);
endinterface

// File: rtl/edge_evt_chan.sv
// One monitored channel: edge detect against the previous level, a single
// pending event slot with its type, and a sticky overflow flag.
module edge_evt_chan
   import edge_evt_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       primed_i,
   input  logic       a_i,
   input  edge_mode_t mode_i,
   input  logic       grant_i,
   input  logic       clr_i,
   output logic       pend_o,
   output logic       type_o,
   output logic       ovf_o
);

   logic prev_q;
   logic pend_q, pend_d;
   logic type_q, type_d;
   logic ovf_q, ovf_d;
   logic rise, fall, qual, drop;

   always_comb begin
      rise   = a_i & ~prev_q;
      fall   = ~a_i & prev_q;
      qual   = primed_i & edge_qualify(mode_i, rise, fall);
      // A grant this cycle frees the slot, so the new edge replaces the old event.
      drop   = qual & pend_q & ~grant_i;
      pend_d = pend_q;
      type_d = type_q;
      if (qual && !drop) begin
         pend_d = 1'b1;
         type_d = rise;
      end else if (grant_i) begin
         pend_d = 1'b0;
      end
      ovf_d  = (ovf_q & ~clr_i) | drop;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q <= 1'b0;
         pend_q <= 1'b0;
         type_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         prev_q <= a_i;
         pend_q <= pend_d;
         type_q <= type_d;
         ovf_q  <= ovf_d;
      end
   end

   assign pend_o = pend_q;
   assign type_o = type_q;
   assign ovf_o  = ovf_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel edge detection feeding a round-robin arbiter that presents one
// pending event at a time on a registered valid/ready output.
module edge_event_arbiter
   import edge_evt_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int CH_W = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N_CH-1:0]      a_i,
   input  logic [2*N_CH-1:0]    mode_i,
   edge_event_arbiter_if.master evt_if,
   output logic [N_CH-1:0]      ovf_o,
   input  logic [N_CH-1:0]      ovf_clr_i
);

   localparam int IDX_W = $clog2(N_CH);

   logic            primed_q;
   logic [N_CH-1:0] pend, ptype, grant;
   logic [CH_W-1:0] rr_q, rr_d;
   logic [CH_W-1:0] gnt_ch;
   logic            gnt_type;
   logic            found, slot_free;
   logic [IDX_W-1:0] sel;
   logic            valid_q, valid_d;
   logic [CH_W-1:0] ch_q, ch_d;
   logic            rise_q, rise_d;

   for (genvar c = 0; c < N_CH; c++) begin : g_chan
      edge_evt_chan u_chan (
         .clk      (clk),
         .reset_n  (reset_n),
         .primed_i (primed_q),
         .a_i      (a_i[c]),
         .mode_i   (edge_mode_t'(mode_i[2*c+1 -: 2])),
         .grant_i  (grant[c]),
         .clr_i    (ovf_clr_i[c]),
         .pend_o   (pend[c]),
         .type_o   (ptype[c]),
         .ovf_o    (ovf_o[c])
      );
   end

   always_comb begin
      found     = 1'b0;
      gnt_ch    = '0;
      gnt_type  = 1'b0;
      grant     = '0;
      sel       = '0;
      slot_free = ~valid_q | evt_if.evt_ready_i;
      // Search starts one past the last granted channel so every channel gets a turn.
      for (int i = 1; i <= N_CH; i++) begin
         sel = IDX_W'((int'(rr_q) + i) % N_CH);
         if (!found && pend[sel]) begin
            found      = 1'b1;
            gnt_ch     = CH_W'(sel);
            gnt_type   = ptype[sel];
            grant[sel] = slot_free;
         end
      end

      valid_d = valid_q;
      ch_d    = ch_q;
      rise_d  = rise_q;
      rr_d    = rr_q;
      if (slot_free) begin
         valid_d = found;
         if (found) begin
            ch_d   = gnt_ch;
            rise_d = gnt_type;
            rr_d   = gnt_ch;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         primed_q <= 1'b0;
         valid_q  <= 1'b0;
         ch_q     <= '0;
         rise_q   <= 1'b0;
         rr_q     <= CH_W'(N_CH - 1);
      end else begin
         primed_q <= 1'b1;
         valid_q  <= valid_d;
         ch_q     <= ch_d;
         rise_q   <= rise_d;
         rr_q     <= rr_d;
      end
   end

   assign evt_if.evt_valid_o = valid_q;
   assign evt_if.evt_ch_o    = ch_q;
   assign evt_if.evt_rise_o  = rise_q;

endmodule
